// File: rtl/sliding_window_gen_pkg.sv
// sliding_window_gen_pkg: default geometry, derived window constants and packed-window index helper.
package sliding_window_gen_pkg;
  localparam int DEF_PIX_BIT = 8;
  localparam int DEF_MASK_WIDTH = 7;
  localparam int DEF_IMG_WIDTH = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_COL_BIT = 10;
  localparam int DEF_ROW_BIT = 9;
  localparam int WIN_TAPS = DEF_MASK_WIDTH ** 2;
  localparam int LB_LINES = DEF_MASK_WIDTH - 1;
  function automatic int win_idx(input int r, input int c, input int mw);
    return r * mw + c;
  endfunction
endpackage

// File: rtl/swg_line_ram.sv
// swg_line_ram: one image line of pixels, read-before-write with registered read.
module swg_line_ram #(
  parameter int PIX_BIT = 8,
  parameter int DEPTH = 640,
  parameter int AW = 10
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [PIX_BIT-1:0] din,
  output logic [PIX_BIT-1:0] dout
);
  logic [PIX_BIT-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      dout <= mem[addr];
      if (we) mem[addr] <= din;
    end
endmodule

// File: rtl/sliding_window_gen.sv
// sliding_window_gen: raster-scan MASK_WIDTH x MASK_WIDTH window generator feeding the filter.
// Define SWG_COORD_EN to add window-centre coordinate outputs win_row/win_col.
module sliding_window_gen
  import sliding_window_gen_pkg::*;
#(
  parameter int PIX_BIT = DEF_PIX_BIT,
  parameter int MASK_WIDTH = DEF_MASK_WIDTH,
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int COL_BIT = DEF_COL_BIT,
  parameter int ROW_BIT = DEF_ROW_BIT
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [PIX_BIT-1:0]                     pix_in,
  input  logic                                   pix_valid,
  input  logic                                   sof,
  output logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] p,
  output logic                                   win_valid,
  output logic                                   win_last
`ifdef SWG_COORD_EN
  ,
  output logic [ROW_BIT-1:0]                     win_row,
  output logic [COL_BIT-1:0]                     win_col
`endif
);
  localparam int TAPS = MASK_WIDTH * MASK_WIDTH;
  localparam int LINES = MASK_WIDTH - 1;
  localparam int WB = $clog2(LINES + 1);
  logic [COL_BIT-1:0] col, cur_col;
  logic [ROW_BIT-1:0] row, cur_row;
  logic [WB-1:0] wp, wp1;
  logic [PIX_BIT-1:0] pix1;
  logic [PIX_BIT-1:0] lb_q [LINES];
  logic [PIX_BIT-1:0] win [MASK_WIDTH][MASK_WIDTH];
  logic [PIX_BIT-1:0] sh [MASK_WIDTH][MASK_WIDTH];
  logic [PIX_BIT*TAPS-1:0] sh_p;
  logic v1, w1, l1, eol;
  assign cur_col = sof ? '0 : col;
  assign cur_row = sof ? '0 : row;
  assign eol = cur_col == COL_BIT'(IMG_WIDTH - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col <= '0;
      row <= '0;
      wp <= '0;
    end else if (pix_valid) begin
      col <= eol ? '0 : cur_col + 1'b1;
      row <= !eol ? cur_row : cur_row == ROW_BIT'(IMG_HEIGHT - 1) ? '0 : cur_row + 1'b1;
      wp <= !eol ? wp : wp == WB'(LINES - 1) ? '0 : wp + 1'b1;
    end
  genvar i;
  for (i = 0; i < LINES; i++) begin : g_lb
    swg_line_ram #(.PIX_BIT(PIX_BIT), .DEPTH(IMG_WIDTH), .AW(COL_BIT)) u_ram (
      .clk(clk), .en(pix_valid), .we(wp == WB'(i)), .addr(cur_col), .din(pix_in), .dout(lb_q[i])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v1 <= 1'b0;
      w1 <= 1'b0;
      l1 <= 1'b0;
      pix1 <= '0;
      wp1 <= '0;
    end else begin
      v1 <= pix_valid;
      w1 <= pix_valid && cur_row >= ROW_BIT'(MASK_WIDTH - 1) && cur_col >= COL_BIT'(MASK_WIDTH - 1);
      l1 <= pix_valid && eol && cur_row == ROW_BIT'(IMG_HEIGHT - 1);
      if (pix_valid) begin
        pix1 <= pix_in;
        wp1 <= wp;
      end
    end
  // Line wp1 holds the oldest row, so window row r comes from line (wp1 + r) mod LINES.
  always_comb begin
    sh_p = '0;
    for (int r = 0; r < MASK_WIDTH; r++) begin
      for (int c = 0; c < MASK_WIDTH - 1; c++) sh[r][c] = win[r][c+1];
      sh[r][MASK_WIDTH-1] = pix1;
      for (int j = 0; j < LINES; j++)
        if (r < LINES && wp1 == WB'((j + LINES - r) % LINES)) sh[r][MASK_WIDTH-1] = lb_q[j];
    end
    for (int r = 0; r < MASK_WIDTH; r++)
      for (int c = 0; c < MASK_WIDTH; c++) sh_p[PIX_BIT*win_idx(r, c, MASK_WIDTH) +: PIX_BIT] = sh[r][c];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      win <= '{default: '0};
      p <= '0;
      win_valid <= 1'b0;
      win_last <= 1'b0;
    end else begin
      if (v1) win <= sh;
      if (w1) p <= sh_p;
      win_valid <= w1;
      win_last <= l1;
    end
`ifdef SWG_COORD_EN
  logic [ROW_BIT-1:0] row1;
  logic [COL_BIT-1:0] col1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      row1 <= '0;
      col1 <= '0;
      win_row <= '0;
      win_col <= '0;
    end else begin
      if (pix_valid) begin
        row1 <= cur_row - ROW_BIT'((MASK_WIDTH - 1) / 2);
        col1 <= cur_col - COL_BIT'((MASK_WIDTH - 1) / 2);
      end
      if (w1) begin
        win_row <= row1;
        win_col <= col1;
      end
    end
`endif
endmodule

// File: tb/tb_sliding_window_gen.sv
// tb_sliding_window_gen: randomized self-checking bench against a frame-array reference model.
module tb_sliding_window_gen;
  localparam int PB = 8, MW = 7, W = 10, H = 8, CB = 4, RB = 3, TAPS = MW * MW;
  typedef struct {
    logic [PB*TAPS-1:0] p;
    logic last;
    int edge_n;
    int r;
    int c;
  } win_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [PB-1:0] pix_in = '0;
  logic pix_valid = 1'b0, sof = 1'b0;
  logic [PB*TAPS-1:0] p;
  logic win_valid, win_last;
`ifdef SWG_COORD_EN
  logic [RB-1:0] win_row;
  logic [CB-1:0] win_col;
`endif
  sliding_window_gen #(
    .PIX_BIT(PB), .MASK_WIDTH(MW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_BIT(CB), .ROW_BIT(RB)
  ) dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .p(p), .win_valid(win_valid), .win_last(win_last)
`ifdef SWG_COORD_EN
    , .win_row(win_row), .win_col(win_col)
`endif
  );
  always #5 clk = ~clk;
  int edge_cnt = 0, n_chk = 0, n_fail = 0, stray = 0, mrow = 0, mcol = 0;
  logic [PB-1:0] img [H][W];
  win_t exp_q[$], obs_q[$];
  win_t mon_o;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(negedge clk)
    if (!reset) begin
      if (win_valid) begin
        mon_o.p = p;
        mon_o.last = win_last;
        mon_o.edge_n = edge_cnt;
`ifdef SWG_COORD_EN
        mon_o.r = int'(win_row);
        mon_o.c = int'(win_col);
`else
        mon_o.r = 0;
        mon_o.c = 0;
`endif
        obs_q.push_back(mon_o);
      end else if (win_last) stray++;
    end
  // Drive one cycle; the model assigns raster coordinates and predicts any complete window.
  task automatic drive(input logic v, input logic s);
    win_t e;
    @(posedge clk);
    #1;
    pix_valid = v;
    sof = s;
    if (v) begin
      if (s) begin
        mrow = 0;
        mcol = 0;
      end
      pix_in = PB'((mrow * 16 + mcol) % 256);
      img[mrow][mcol] = pix_in;
      if (mrow >= MW - 1 && mcol >= MW - 1) begin
        e.p = '0;
        for (int r = 0; r < MW; r++)
          for (int c = 0; c < MW; c++) e.p[PB*(r*MW+c) +: PB] = img[mrow-MW+1+r][mcol-MW+1+c];
        e.last = (mrow == H - 1 && mcol == W - 1);
        e.edge_n = edge_cnt + 2;
`ifdef SWG_COORD_EN
        e.r = mrow - (MW - 1) / 2;
        e.c = mcol - (MW - 1) / 2;
`else
        e.r = 0;
        e.c = 0;
`endif
        exp_q.push_back(e);
      end
      if (mcol == W - 1) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else mcol++;
    end else pix_in = PB'($urandom);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (p !== '0) begin n_fail++; $display("FAIL reset_p: got %h want 0", p); end
    n_chk++;
    if (win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", win_valid); end
    n_chk++;
    if (win_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", win_last); end
    reset = 1'b0;
  endtask
  task automatic test_frame();
    exp_q.delete();
    obs_q.delete();
    mrow = 0;
    mcol = 0;
    repeat (W * H) drive(1'b1, 1'b0);
    repeat (4) drive(1'b0, 1'b0);
    n_chk++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++; $display("FAIL frame_count: got %0d want 8 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i].p !== exp_q[i].p || obs_q[i].last !== exp_q[i].last || obs_q[i].edge_n != exp_q[i].edge_n
          || obs_q[i].r != exp_q[i].r || obs_q[i].c != exp_q[i].c) begin
        n_fail++;
        $display("FAIL frame_win%0d: got p=%h last=%b edge=%0d rc=%0d,%0d want p=%h last=%b edge=%0d rc=%0d,%0d", i,
                 obs_q[i].p, obs_q[i].last, obs_q[i].edge_n, obs_q[i].r, obs_q[i].c,
                 exp_q[i].p, exp_q[i].last, exp_q[i].edge_n, exp_q[i].r, exp_q[i].c);
      end
    end
    if (obs_q.size() > 0) begin
      n_chk++;
      if (obs_q[0].p[0 +: PB] !== 8'h00 || obs_q[0].p[PB*6 +: PB] !== 8'h06 || obs_q[0].p[PB*48 +: PB] !== 8'h66) begin
        n_fail++;
        $display("FAIL first_win_taps: got k0=%h k6=%h k48=%h want 00 06 66",
                 obs_q[0].p[0 +: PB], obs_q[0].p[PB*6 +: PB], obs_q[0].p[PB*48 +: PB]);
      end
      n_chk++;
      if (obs_q[$].p[0 +: PB] !== 8'h13 || obs_q[$].p[PB*48 +: PB] !== 8'h79 || obs_q[$].last !== 1'b1) begin
        n_fail++;
        $display("FAIL last_win_taps: got k0=%h k48=%h last=%b want 13 79 1",
                 obs_q[$].p[0 +: PB], obs_q[$].p[PB*48 +: PB], obs_q[$].last);
      end
`ifdef SWG_COORD_EN
      n_chk++;
      if (obs_q[0].r != 3 || obs_q[0].c != 3 || obs_q[$].r != 4 || obs_q[$].c != 6) begin
        n_fail++;
        $display("FAIL coord: got first %0d,%0d last %0d,%0d want 3,3 and 4,6",
                 obs_q[0].r, obs_q[0].c, obs_q[$].r, obs_q[$].c);
      end
`endif
    end
    n_chk++;
    if (stray != 0) begin n_fail++; $display("FAIL frame_stray_last: got %0d want 0", stray); end
  endtask
  task automatic test_gaps();
    int acc = 0;
    logic v;
    exp_q.delete();
    obs_q.delete();
    while (acc < W * H) begin
      v = 1'($urandom_range(0, 1));
      drive(v, v && acc == 0);
      if (v) acc++;
    end
    repeat (4) drive(1'b0, 1'b0);
    n_chk++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++; $display("FAIL gaps_count: got %0d want 8 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i].p !== exp_q[i].p || obs_q[i].last !== exp_q[i].last || obs_q[i].edge_n != exp_q[i].edge_n) begin
        n_fail++;
        $display("FAIL gaps_win%0d: got p=%h last=%b edge=%0d want p=%h last=%b edge=%0d", i,
                 obs_q[i].p, obs_q[i].last, obs_q[i].edge_n, exp_q[i].p, exp_q[i].last, exp_q[i].edge_n);
      end
    end
  endtask
  task automatic test_sof_mid();
    exp_q.delete();
    obs_q.delete();
    drive(1'b1, 1'b1);
    repeat (9) drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    repeat (24) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    repeat (W * H - 1) drive(1'b1, 1'b0);
    repeat (4) drive(1'b0, 1'b0);
    n_chk++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++; $display("FAIL sof_count: got %0d want 8 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i].p !== exp_q[i].p || obs_q[i].last !== exp_q[i].last || obs_q[i].edge_n != exp_q[i].edge_n) begin
        n_fail++;
        $display("FAIL sof_win%0d: got p=%h last=%b edge=%0d want p=%h last=%b edge=%0d", i,
                 obs_q[i].p, obs_q[i].last, obs_q[i].edge_n, exp_q[i].p, exp_q[i].last, exp_q[i].edge_n);
      end
    end
  endtask
  task automatic test_reset_mid();
    exp_q.delete();
    obs_q.delete();
    drive(1'b1, 1'b1);
    repeat (67) drive(1'b1, 1'b0);
    @(posedge clk);
    #2;
    n_chk++;
    if (win_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", win_valid); end
    pix_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_chk++;
    if (win_valid !== 1'b0 || win_last !== 1'b0 || p !== '0) begin
      n_fail++; $display("FAIL async_reset: got valid=%b last=%b p=%h want 0 0 0", win_valid, win_last, p);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    mrow = 0;
    mcol = 0;
    drive(1'b1, 1'b1);
    repeat (W * H - 1) drive(1'b1, 1'b0);
    repeat (4) drive(1'b0, 1'b0);
    n_chk++;
    if (obs_q.size() != 8 || exp_q.size() != 8) begin
      n_fail++; $display("FAIL rst_count: got %0d want 8 (model %0d)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (obs_q[i].p !== exp_q[i].p || obs_q[i].last !== exp_q[i].last || obs_q[i].edge_n != exp_q[i].edge_n) begin
        n_fail++;
        $display("FAIL rst_win%0d: got p=%h last=%b edge=%0d want p=%h last=%b edge=%0d", i,
                 obs_q[i].p, obs_q[i].last, obs_q[i].edge_n, exp_q[i].p, exp_q[i].last, exp_q[i].edge_n);
      end
    end
  endtask
  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_sof_mid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
Raster-scan window generator that sits directly upstream of the 7x7 filter function.
- Accepts one pixel per cycle.
- Stores MASK_WIDTH-1 full image lines in ring-addressed line buffers.
- Presents a fully packed MASK_WIDTH x MASK_WIDTH pixel window on the filter's pixel bus, with a valid strobe that drives the filter's enable.
- Only fully populated windows are emitted; no border padding.

Parameters:
PIX_BIT, 8, bits per pixel
MASK_WIDTH, 7, window side length
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
COL_BIT, 10, column counter width (2**COL_BIT >= IMG_WIDTH)
ROW_BIT, 9, row counter width (2**ROW_BIT >= IMG_HEIGHT)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
pix_in  in  PIX_BIT  input pixel, unsigned
pix_valid  in  1  pix_in accepted this cycle
sof  in  1  start of frame; qualified by pix_valid, marks pixel (0,0)
p  out  PIX_BIT*MASK_WIDTH**2  packed window
win_valid  out  1  p holds a valid window this cycle (single-cycle strobe)
win_last  out  1  window is the last of the frame (coincident with win_valid)

Behaviour:
- Reset values:
  - p = 0, win_valid = 0, win_last = 0.
  - Row and column counters = 0.
  - Line buffer contents are don't-care.
- Counters:
  - Each accepted pixel (pix_valid=1) is at (row, col).
  - col increments and wraps IMG_WIDTH-1 -> 0; row increments on wrap.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
- sof:
  - sof=1 with pix_valid=1 forces that pixel to (0,0), even mid-frame.
  - sof without pix_valid is ignored.
- Line buffers:
  - MASK_WIDTH-1 lines of IMG_WIDTH x PIX_BIT each.
  - Column col supplies the pixels at (row-1..row-MASK_WIDTH+1, col).
  - The new pixel is written into the youngest line; older lines shift down by ring pointer, not by copy.
  - Same-column read precedes write.
- Window register:
  - MASK_WIDTH x MASK_WIDTH; shifts left by one column per accepted pixel.
  - It does not shift when pix_valid=0.
- Packing:
  - Element k = r*MASK_WIDTH + c occupies p[PIX_BIT*(k+1)-1 : PIX_BIT*k].
  - r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
  - Element MASK_WIDTH**2-1 is the newest pixel.
  - Index order matches coefficient order in the filter.
- Latency:
  - The window whose bottom-right pixel is accepted at cycle T appears on p at cycle T+2.
  - Latency is fixed and independent of pix_valid gaps.
- Valid condition:
  - win_valid=1 at T+2 iff the pixel at T had row >= MASK_WIDTH-1 and col >= MASK_WIDTH-1.
  - Windows never straddle lines: on a new line, the leftmost MASK_WIDTH-1 columns are not valid.
- win_last:
  - win_last=1 with the window for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- p hold behaviour:
  - p holds its last value while win_valid=0.
  - The consumer samples p only when win_valid=1.
- Back-to-back pixels give one window per cycle; there is no stall or backpressure.
- Mid-frame sof:
  - Windows in flight from the old frame still emerge.
  - The first window of the new frame requires MASK_WIDTH-1 new full lines, so stale buffer data is never flagged valid.
- Reset mid-operation:
  - Outputs go 0 asynchronously and pipeline strobes clear.
  - The next frame must begin with sof.

Optional Feature:
Macro SWG_COORD_EN.
- Defined:
  - Adds outputs win_row [ROW_BIT-1:0] and win_col [COL_BIT-1:0] giving the window centre (row-(MASK_WIDTH-1)/2, col-(MASK_WIDTH-1)/2).
  - They are registered alongside p with the same T+2 latency and reset to 0.
- Undefined:
  - Ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - default PIX_BIT, MASK_WIDTH, IMG_WIDTH, IMG_HEIGHT;
  - derived constants WIN_TAPS = MASK_WIDTH**2 and LB_LINES = MASK_WIDTH-1;
  - the packed-window index function (r,c) -> k.
- One sub-module: swg_line_ram.
  - Single-port-style read-before-write RAM of IMG_WIDTH x PIX_BIT with registered read.
  - Instantiated LB_LINES times.

Test Plan:
All scenarios use IMG_WIDTH=10, IMG_HEIGHT=8, pix = (row*16+col) mod 256, continuous pix_valid unless stated.
- Frame 1 from reset:
  - First win_valid occurs 2 cycles after pixel (6,6).
  - Element k=0 = 0x00, element k=48 = 0x66, element k=6 = 0x06.
  - Exactly 8 windows per frame.
- win_last:
  - Asserted only on the window for (7,9): k=48 = 0x79, k=0 = 0x13.
  - win_valid deasserts the following cycle.
- Random pix_valid gaps (50% duty):
  - Window contents and count match the gapless case.
  - Each window appears exactly 2 cycles after its bottom-right pixel.
- sof asserted at pixel (3,4) of frame 1:
  - No window is flagged valid until the new frame's pixel (6,6).
  - The new frame's windows match the golden model.
- reset pulsed mid-frame (asynchronous, between clock edges):
  - win_valid, win_last and p read 0 immediately.
  - A following sof-started frame produces the correct 8 windows.
- SWG_COORD_EN defined:
  - The first window reports win_row=3, win_col=3.
  - The last window reports win_row=4, win_col=6.
